// File: rtl/pc_pkg.sv
// pc_pkg: shared PC-source encoding and parameter defaults for the program-counter unit
package pc_pkg;
  typedef enum logic [2:0] {SRC_SEQ, SRC_BR, SRC_CALL, SRC_RET, SRC_TRAP} pc_src_t;
  localparam int PC_ADDR_W    = 16;
  localparam int PC_STEP      = 1;
  localparam int PC_RESET_VEC = 0;
  localparam int PC_TRAP_VEC  = 16'h0004;
  localparam int PC_RAS_DEPTH = 4;
endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack; a push when full overwrites the oldest entry
module ras_stack
  import pc_pkg::*;
#(
  parameter int DEPTH = PC_RAS_DEPTH,
  parameter int W     = PC_ADDR_W,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  push_data,
  output logic [W-1:0]  top,
  output logic [CW-1:0] count,
  output logic          ovf,
  output logic          unf
);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d, ptr_inc, ptr_dec;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d, unf_q, unf_d, empty, full;
  // ptr_q is the next write slot, so the top entry sits one slot behind it
  always_comb begin
    ptr_inc = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
    ptr_dec = (ptr_q == '0) ? LAST : ptr_q - 1'b1;
    empty   = (cnt_q == '0);
    full    = (cnt_q == FULL);
    ptr_d   = push ? ptr_inc : (pop && !empty) ? ptr_dec : ptr_q;
    cnt_d   = push ? (full ? cnt_q : cnt_q + 1'b1) : (pop && !empty) ? cnt_q - 1'b1 : cnt_q;
    ovf_d   = ovf_q | (push & full);
    unf_d   = unf_q | (pop & empty);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  always_ff @(posedge clk)
    if (push) mem_q[ptr_q] <= push_data;
  assign top   = mem_q[ptr_dec];
  assign count = cnt_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;
endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with priority next-address mux (trap > ret > call > redirect > seq)
module pc_unit
  import pc_pkg::*;
#(
  parameter int ADDR_W    = PC_ADDR_W,
  parameter int STEP      = PC_STEP,
  parameter int RESET_VEC = PC_RESET_VEC,
  parameter int TRAP_VEC  = PC_TRAP_VEC,
  parameter int RAS_DEPTH = PC_RAS_DEPTH
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           pc_we,
  input  logic                           redirect,
  input  logic                           call,
  input  logic                           ret,
  input  logic                           trap,
  input  logic [ADDR_W-1:0]              target,
  output logic [ADDR_W-1:0]              currentAddress,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_ovf,
  output logic                           ras_unf
);
  localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_VEC);
  localparam logic [ADDR_W-1:0] TRAP_PC  = ADDR_W'(TRAP_VEC);
  pc_src_t           src;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, ras_top;
  logic              push, pop;
  // trap overrides a stall; every other source only acts when pc_we is high
  always_comb begin
    src    = trap ? SRC_TRAP : ret ? SRC_RET : call ? SRC_CALL : redirect ? SRC_BR : SRC_SEQ;
    pc_inc = pc_q + ADDR_W'(STEP);
    push   = pc_we && (src == SRC_CALL);
    pop    = pc_we && (src == SRC_RET);
    pc_d   = !(trap || pc_we) ? pc_q :
             (src == SRC_TRAP) ? TRAP_PC :
             (src == SRC_RET) ? ((ras_count != '0) ? ras_top : pc_inc) :
             (src == SRC_CALL || src == SRC_BR) ? target : pc_inc;
  end
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  ras_stack #(.DEPTH(RAS_DEPTH), .W(ADDR_W)) u_ras (
    .clk       (CLK),
    .rst_n     (RESET),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top       (ras_top),
    .count     (ras_count),
    .ovf       (ras_ovf),
    .unf       (ras_unf)
  );
  assign currentAddress = pc_q;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: vector table, directed corner sequences and randomized run against a queue-based model
module tb_pc_unit;
  logic        CLK = 1'b0;
  logic        RESET, pc_we, redirect, call, ret, trap;
  logic [15:0] target, currentAddress;
  logic [2:0]  ras_count;
  logic        ras_ovf, ras_unf;
  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] m_pc;
  logic [15:0] m_ras[$];
  logic        m_ovf, m_unf;
  typedef struct {
    logic we, br, cl, rt, tp;
    logic [15:0] tgt;
    logic [15:0] e_pc;
    int e_cnt;
  } vec_t;
  vec_t vt[16];
  logic [15:0] exp_ret[4];

  pc_unit dut (
    .CLK(CLK), .RESET(RESET), .pc_we(pc_we), .redirect(redirect), .call(call),
    .ret(ret), .trap(trap), .target(target), .currentAddress(currentAddress),
    .ras_count(ras_count), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set(input logic we, br, cl, rt, tp, input logic [15:0] tgt);
    pc_we = we; redirect = br; call = cl; ret = rt; trap = tp; target = tgt;
  endtask

  task automatic model_step();
    if (trap) m_pc = 16'h0004;
    else if (pc_we) begin
      if (ret) begin
        if (m_ras.size() > 0) m_pc = m_ras.pop_back();
        else begin m_pc = m_pc + 16'd1; m_unf = 1'b1; end
      end else if (call) begin
        m_ras.push_back(m_pc + 16'd1);
        if (m_ras.size() > 4) begin m_ras = m_ras[1:$]; m_ovf = 1'b1; end
        m_pc = target;
      end else if (redirect) m_pc = target;
      else m_pc = m_pc + 16'd1;
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0; m_ras.delete(); m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic cycle();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".pc"},  32'(currentAddress), 32'(m_pc));
    chk({tag, ".cnt"}, 32'(ras_count),      32'(m_ras.size()));
    chk({tag, ".ovf"}, 32'(ras_ovf),        32'(m_ovf));
    chk({tag, ".unf"}, 32'(ras_unf),        32'(m_unf));
  endtask

  initial begin
    vt[0]  = '{1,0,0,0,0,16'h0000,16'h0001,0};
    vt[1]  = '{1,0,0,0,0,16'h0000,16'h0002,0};
    vt[2]  = '{1,0,0,0,0,16'h0000,16'h0003,0};
    vt[3]  = '{1,0,0,0,0,16'h0000,16'h0004,0};
    vt[4]  = '{1,0,0,0,0,16'h0000,16'h0005,0};
    vt[5]  = '{1,1,0,0,0,16'h0040,16'h0040,0};
    vt[6]  = '{0,0,0,0,0,16'h0000,16'h0040,0};
    vt[7]  = '{0,0,0,0,0,16'h0000,16'h0040,0};
    vt[8]  = '{1,0,0,0,0,16'h0000,16'h0041,0};
    vt[9]  = '{1,1,0,0,0,16'h0010,16'h0010,0};
    vt[10] = '{1,0,1,0,0,16'h0100,16'h0100,1};
    vt[11] = '{1,0,1,0,0,16'h0200,16'h0200,2};
    vt[12] = '{1,0,0,1,0,16'h0000,16'h0101,1};
    vt[13] = '{1,0,0,1,0,16'h0000,16'h0011,0};
    vt[14] = '{1,1,1,0,0,16'h0300,16'h0300,1};
    vt[15] = '{1,1,0,1,0,16'h0999,16'h0012,0};
    exp_ret = '{16'h0531, 16'h0521, 16'h0511, 16'h0501};

    RESET = 1'b0;
    set(1, 0, 0, 0, 0, 16'h0);
    model_reset();
    #12;
    chk_model("reset");
    RESET = 1'b1;

    foreach (vt[i]) begin
      set(vt[i].we, vt[i].br, vt[i].cl, vt[i].rt, vt[i].tp, vt[i].tgt);
      cycle();
      chk($sformatf("vec%0d.pc", i),  32'(currentAddress), 32'(vt[i].e_pc));
      chk($sformatf("vec%0d.cnt", i), 32'(ras_count),      32'(vt[i].e_cnt));
    end
    chk_model("table_end");

    for (int i = 0; i < 5; i++) begin
      set(1, 0, 1, 0, 0, 16'h0500 + 16'(i * 16));
      cycle();
    end
    chk("ovf_pc",  32'(currentAddress), 32'h0540);
    chk("ovf_cnt", 32'(ras_count),      32'd4);
    chk("ovf_set", 32'(ras_ovf),        32'd1);
    for (int i = 0; i < 4; i++) begin
      set(1, 0, 0, 1, 0, 16'h0);
      cycle();
      chk($sformatf("ret%0d.pc", i), 32'(currentAddress), 32'(exp_ret[i]));
    end
    chk("unf_clear", 32'(ras_unf), 32'd0);
    cycle();
    chk("unf_pc",  32'(currentAddress), 32'h0502);
    chk("unf_set", 32'(ras_unf),        32'd1);
    chk("unf_cnt", 32'(ras_count),      32'd0);

    set(1, 0, 1, 0, 0, 16'h0700);
    cycle();
    set(0, 0, 1, 0, 1, 16'h0123);
    cycle();
    chk("trap_pc",  32'(currentAddress), 32'h0004);
    chk("trap_cnt", 32'(ras_count),      32'd1);
    set(1, 1, 0, 0, 0, 16'hFFFF);
    cycle();
    set(1, 0, 0, 0, 0, 16'h0);
    cycle();
    chk("wrap_pc", 32'(currentAddress), 32'h0000);
    cycle();
    chk_model("pre_reset");

    set(1, 0, 1, 0, 0, 16'h0800);
    #2;
    RESET = 1'b0;
    model_reset();
    #1;
    chk_model("async_reset");
    @(posedge CLK);
    #1;
    chk_model("reset_hold");
    #3;
    RESET = 1'b1;
    set(0, 0, 0, 0, 0, 16'h0);

    for (int i = 0; i < 400; i++) begin
      set($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0, 16'($urandom));
      if (i % 97 == 0) target = 16'hFFFF;
      cycle();
      chk_model($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
